cp0_irq_ctrl: RTL

//  CPU-side consumer of the peripheral interrupt lines (timer IRQ and future devices): a MIPS

---
 rtl/cp0_irq_ctrl_pkg.sv | 24 ++
 rtl/cp0_irq_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions, reset values and
// the word-alignment helper used for EPC.
package cp0_irq_ctrl_pkg;

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int IP_HI   = 15;
    localparam int IP_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    localparam logic [31:0] SR_RST_VAL = 32'h0000_FC01;

    // EPC always holds a word-aligned address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl.sv
// MIPS coprocessor-0 subset (SR, Cause, EPC, PRId): masks hardware interrupts,
// raises int_req to the pipeline and captures/returns the exception PC.
module cp0_irq_ctrl
    import cp0_irq_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID_VAL  = 32'h4D49_5053,
    parameter int          NUM_HWINT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic [4:0]           rd_sel,
    input  logic [4:0]           wr_sel,
    input  logic                 we,
    input  logic [31:0]          din,
    input  logic [31:0]          pc,
    input  logic                 exl_set,
    input  logic                 exl_clr,
    output logic                 int_req,
    output logic [31:0]          epc,
    output logic [31:0]          dout
);

    logic [NUM_HWINT-1:0] im_q, im_d;
    logic [NUM_HWINT-1:0] ip_q, ip_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic [31:0]          epc_q, epc_d;

    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Later assignments win: mtc0 < exl_clr < exl_set for EXL, mtc0 < exl_set for EPC.
    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;
        ip_d  = hw_int;

        if (we && wr_sel == SEL_SR) begin
            im_d  = din[IM_HI:IM_LO];
            exl_d = din[EXL_BIT];
            ie_d  = din[IE_BIT];
        end
        if (we && wr_sel == SEL_EPC) begin
            epc_d = word_align(din);
        end
        if (exl_clr) begin
            exl_d = 1'b0;
        end
        if (exl_set) begin
            exl_d = 1'b1;
            epc_d = word_align(pc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q  <= SR_RST_VAL[IM_HI:IM_LO];
            exl_q <= SR_RST_VAL[EXL_BIT];
            ie_q  <= SR_RST_VAL[IE_BIT];
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        sr_word                = '0;
        sr_word[IM_HI:IM_LO]   = im_q;
        sr_word[EXL_BIT]       = exl_q;
        sr_word[IE_BIT]        = ie_q;
        cause_word             = '0;
        cause_word[IP_HI:IP_LO] = ip_q;
    end

    // Reads see registered state only, so a same-cycle mtc0 is not visible yet.
    always_comb begin
        case (rd_sel)
            SEL_SR:    dout = sr_word;
            SEL_CAUSE: dout = cause_word;
            SEL_EPC:   dout = epc_q;
            SEL_PRID:  dout = PRID_VAL;
            default:   dout = '0;
        endcase
    end

    assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign epc     = epc_q;

endmodule
